// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the multiplexed seven-segment
// display driver.
//   SEG_BLANK  : catode value with every segment and the dp dark
//   ANODE_OFF  : anode value with no digit selected
//   DIGITS     : number of multiplexed digits
//   HEX_SEG    : active-low a..g patterns for hex digits 0..F (bit 0 = a)
package seg7_pkg;

  localparam int          DIGITS    = 4;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [3:0]  ANODE_OFF = 4'hF;
  localparam logic [6:0]  SEG_OFF   = 7'h7F;

  // Digit select for the scan; one value per multiplexed digit.
  typedef logic [1:0] digit_t;

  // Active-low segment patterns, dp excluded.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex digit to active-low seven-segment decode.
//   nibble : 4-bit hex value
//   seg    : active-low segments, seg[0]=a .. seg[6]=g
module hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans a latched 16-bit value onto a 4-digit multiplexed
// seven-segment display, one digit per refresh slot, with a one-cycle
// all-off blank at the start of every slot to suppress ghosting.
//   clk, reset : system clock, synchronous active-high reset
//   data_in    : value to show; nibble i drives digit i (digit 0 rightmost)
//   dp_in      : decimal-point enables, bit i for digit i, 1 = lit
//   load       : strobe; when high at an edge data_in/dp_in are latched
//   blank_lz   : 1 = suppress leading zeros (used live, not latched)
//   anode      : active-low one-hot digit select, anode[0] = digit 0
//   catode     : active-low segments, catode[6:0] = g..a, catode[7] = dp
//
// The scan state is prescaler + index. The slot phase is implicit: the
// edge on which the prescaler wraps (tick) produces the blank cycle, every
// other edge drives the digit selected by index. Both outputs are
// registered, so nothing on the input side reaches the pins combinationally.
// REFRESH_DIV must be at least 2, otherwise every edge would be a blank.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter  int REFRESH_DIV = 100000,
  localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  anode,
  output logic [7:0]  catode
);

  localparam logic [CNT_W-1:0] PRESCALE_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      shadow;
  logic [3:0]       dp_shadow;
  logic [CNT_W-1:0] prescaler;
  digit_t           index;

  logic             tick;
  logic [3:0]       nibble;
  logic [6:0]       seg_raw;
  logic             lz_blank;
  logic [6:0]       seg_disp;

  assign tick   = (prescaler == PRESCALE_LAST);
  assign nibble = shadow[{index, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // A digit is a leading zero when it and every more significant nibble
  // are zero. Digit 0 is exempt so an all-zero value still reads "0".
  always_comb begin
    lz_blank = 1'b0;
    case (index)
      2'd1:    lz_blank = (shadow[15:4]  == 12'h000);
      2'd2:    lz_blank = (shadow[15:8]  == 8'h00);
      2'd3:    lz_blank = (shadow[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
    lz_blank = lz_blank & blank_lz;
  end

  // A suppressed digit keeps its anode and dp; only a..g go dark.
  assign seg_disp = lz_blank ? SEG_OFF : seg_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      dp_shadow <= '0;
      prescaler <= '0;
      index     <= '0;
      anode     <= ANODE_OFF;
      catode    <= SEG_BLANK;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;

      if (tick) begin
        index  <= index + 2'd1;
        anode  <= ANODE_OFF;
        catode <= SEG_BLANK;
      end else begin
        anode  <= ~(4'b0001 << index);
        catode <= {~dp_shadow[index], seg_disp};
      end

      // The shadow update lands alongside the output update, so new data is
      // first visible one edge after the load (or after the blank on a tick).
      if (load) begin
        shadow    <= data_in;
        dp_shadow <= dp_in;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives the 4-digit multiplexed seven-segment display from a 16-bit value produced by the core, e.g. a register or result value from `top`.
- Sits directly downstream of the core; its outputs go to the board pins `anode` and `catode`.
- Latches a value on a load strobe and scans one digit at a time at a programmable refresh rate.
- Inserts a one-cycle all-off blanking slot at every digit change to suppress ghosting.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2; sets prescaler wrap.
- CNT_W, $clog2(REFRESH_DIV), prescaler width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_in  in  16  value to display; nibble i drives digit i, digit 0 is rightmost
- dp_in  in  4  decimal-point enables, bit i maps to digit i, 1 = lit
- load  in  1  when high on a rising edge, latches data_in and dp_in into the shadow registers
- blank_lz  in  1  1 = suppress leading zeros
- anode  out  4  active-low one-hot digit select; anode[0] is digit 0
- catode  out  8  active-low segments; catode[0]=a … catode[6]=g, catode[7]=dp

Behaviour:
- Reset:
  - Single clock `clk`; reset is synchronous and active-high.
  - Reset takes priority over everything, including load. On a reset edge: shadow=0, dp_shadow=0, prescaler=0, index=0, anode=4'b1111, catode=8'hFF.
  - Reset mid-scan restarts cleanly at digit 0 after release.
- Output timing:
  - All outputs come straight from flops, with no combinational path from inputs to outputs.
  - Next state and outputs are computed from pre-edge values.
- Prescaler:
  - Increments every cycle.
  - When it equals REFRESH_DIV-1, it wraps to 0 and `tick` is asserted for that edge.
- Tick edge:
  - index <= (index+1) mod 4, so 3 wraps to 0.
  - anode <= 4'b1111 and catode <= 8'hFF (blank slot).
- Any non-tick edge:
  - anode <= ~(4'b0001 << index).
  - catode <= {~dp_shadow[index], seg(nibble[index])}, where the decode uses the shadow values as they stand before the edge.
- Resulting digit slot: 1 blank cycle followed by REFRESH_DIV-1 display cycles.
- Load:
  - On a load edge the shadow registers update.
  - The first output reflecting the new value appears one edge later, i.e. a 1-cycle latency, unless that edge is a blank slot.
- Load and tick on the same edge: both take effect. The next cycle is blank, then the new index shows the new data.
- Leading-zero blanking:
  - Applies when blank_lz=1 and i>=1: digit i is blank if shadow nibbles i..3 are all zero.
  - A blanked digit keeps its anode asserted and drives catode[6:0]=7'h7F.
  - Its dp is still honoured.
  - Digit 0 is never blanked, so 16'h0000 displays "0".
  - blank_lz is sampled live; it is not latched by load.
- Hex decode (catode with dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - dp on clears bit 7.

Decomposition:
- Shared package `seg7_pkg`:
  - SEG_BLANK (8'hFF), ANODE_OFF (4'hF), DIGITS=4.
  - The 16-entry hex-to-segment constant table.
- One combinational sub-module, `hex_to_seg` (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.
- The FSM is implicit: prescaler plus index plus a blank/display phase. No separate state-machine module.

Test Plan (all with REFRESH_DIV=4):
1. Reset held for 2 edges → anode=1111, catode=FF. First edge after release → anode=1110, catode=C0.
2. load 16'h1A2F, dp_in=0, blank_lz=0 → sequence per 4-cycle slot:
   - 1110/8E ×3, then blank 1111/FF
   - 1101/A4 ×3, then blank
   - 1011/88 ×3, then blank
   - 0111/F9 ×3, then wrap to 1110.
3. blank_lz=1:
   - Load 16'h0005 → digits 3..1 show catode FF with anode asserted; digit 0 shows 92.
   - Load 16'h0000 → digit 0 shows C0.
4. load 16'h8888, dp_in=4'b0100 → digit 2 catode=00; digits 0, 1, 3 catode=80.
5. load 16'h1234 pulsed on a tick edge, with the old value 16'hFFFF → next cycle 1111/FF, then the new index shows its nibble of 1234 (digit 1 → B0). The old digit never shows 8E after the blank slot.
6. Reset asserted while index=2 in a display cycle → next edge 1111/FF and shadow cleared. After release, digit 0 shows C0 and the scan restarts from the prescaler at 0.
